// File: rtl/led_fade_pwm_pkg.sv
// Shared definitions for the LED fade/PWM stage and its neighbours.
//   NUM_LEDS     : number of LED channels (also used by the LED shifter).
//   PWM_BITS_DEF : default brightness/PWM counter width.
//   max_level()  : full-scale brightness code for a given width.
package led_pkg;

  localparam int NUM_LEDS     = 8;
  localparam int PWM_BITS_DEF = 4;

  function automatic int max_level(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Bundle between the LED shifter side and the LED pins.
//   leds_in   : requested pattern, bit i = LED i on
//   enable    : 1 = run, 0 = freeze levels/counters and blank the pins
//   led_out   : PWM-modulated LED drive (registered)
//   level_dbg : current level of channel i at [i*PWM_BITS +: PWM_BITS]
// Handshake: none. leds_in/enable are level signals sampled on every rising
// clk edge; led_out/level_dbg are registered and valid every cycle.
// master = pattern source / observer, slave = the fade stage.
interface led_fade_pwm_if #(
  parameter int PWM_BITS = led_pkg::PWM_BITS_DEF
);
  import led_pkg::*;

  logic [NUM_LEDS-1:0]          leds_in;
  logic                         enable;
  logic [NUM_LEDS-1:0]          led_out;
  logic [NUM_LEDS*PWM_BITS-1:0] level_dbg;

  modport master (
    output leds_in,
    output enable,
    input  led_out,
    input  level_dbg
  );

  modport slave (
    input  leds_in,
    input  enable,
    output led_out,
    output level_dbg
  );

endinterface

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: brightness level register plus registered PWM compare.
//   clk, rst     : clock, synchronous active-high reset
//   enable_i     : 0 freezes the level and blanks led_o
//   req_i        : synchronised request bit (1 = full brightness)
//   decay_tick_i : one-cycle strobe from the shared decay prescaler
//   pwm_cnt_i    : shared PWM counter
//   level_o      : current level register
//   led_o        : registered PWM output bit
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic                req_i,
  input  logic                decay_tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic [PWM_BITS-1:0] level_o,
  output logic                led_o
);

  localparam int MAX_LEVEL = max_level(PWM_BITS);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;

  always_comb begin
    level_d = level_q;
    led_d   = 1'b0;
    if (enable_i) begin
      // A request wins over decay so a fading channel retriggers at once.
      if (req_i) begin
        level_d = PWM_BITS'(MAX_LEVEL);
      end else if (decay_tick_i) begin
        // Saturate at zero; a step at or above full scale empties in one go.
        if (int'(level_q) > DECAY_STEP) begin
          level_d = level_q - PWM_BITS'(DECAY_STEP);
        end else begin
          level_d = '0;
        end
      end
      // pwm_cnt never reaches MAX_LEVEL, so full scale is 100% duty.
      led_d = (level_q > pwm_cnt_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign level_o = level_q;
  assign led_o   = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade/PWM stage: takes the shifter pattern and drives the LED pins.
// Set bits drive full brightness; cleared bits fade out in DECAY_STEP
// decrements every DECAY_DIV cycles, leaving a trail behind the pattern.
//   clk, rst : clock, synchronous active-high reset
//   bus      : led_fade_pwm_if slave (leds_in, enable -> led_out, level_dbg)
// Latency leds_in -> led_out is three edges: input sync, level, output.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_DIV  = 4,
  parameter int DECAY_STEP = 4
) (
  input  logic           clk,
  input  logic           rst,
  led_fade_pwm_if.slave  bus
);

  localparam int MAX_LEVEL = max_level(PWM_BITS);
  // Keep at least one bit so DECAY_DIV=1 still yields a legal counter.
  localparam int DIV_W     = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [NUM_LEDS-1:0]          leds_q;
  logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
  logic                         decay_tick;
  logic [NUM_LEDS-1:0]          led_w;
  logic [NUM_LEDS*PWM_BITS-1:0] level_w;

  always_comb begin
    decay_tick = bus.enable && (div_cnt_q == DIV_W'(DECAY_DIV - 1));
    pwm_cnt_d  = pwm_cnt_q;
    div_cnt_d  = div_cnt_q;
    if (bus.enable) begin
      // Period is MAX_LEVEL so the top level compares true on every count.
      pwm_cnt_d = (pwm_cnt_q == PWM_BITS'(MAX_LEVEL - 1)) ? '0 : pwm_cnt_q + 1'b1;
      div_cnt_d = decay_tick ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q    <= '0;
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      // The input register keeps sampling while frozen.
      leds_q    <= bus.leds_in;
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .enable_i    (bus.enable),
      .req_i       (leds_q[i]),
      .decay_tick_i(decay_tick),
      .pwm_cnt_i   (pwm_cnt_q),
      .level_o     (level_w[i*PWM_BITS +: PWM_BITS]),
      .led_o       (led_w[i])
    );
  end

  assign bus.led_out   = led_w;
  assign bus.level_dbg = level_w;

endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  led_fade_pwm_if #(.PWM_BITS(4)) ifm ();
  led_fade_pwm_if #(.PWM_BITS(4)) ifs ();

  led_fade_pwm #(.PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(4)) u_dut (
    .clk(clk), .rst(rst), .bus(ifm)
  );

  led_fade_pwm #(.PWM_BITS(4), .DECAY_DIV(64), .DECAY_STEP(4)) u_slow (
    .clk(clk), .rst(rst_s), .bus(ifs)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  leds;
    logic [7:0]  exp_led;
    logic [31:0] exp_lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lvl(input int ch);
    return ifm.level_dbg[ch*4 +: 4];
  endfunction

  function automatic logic [3:0] lvl_s(input int ch);
    return ifs.level_dbg[ch*4 +: 4];
  endfunction

  function automatic void add(input logic r, input logic e, input logic [7:0] l,
                              input logic [7:0] xl, input logic [31:0] xv);
    vec_t v;
    v.rst = r; v.en = e; v.leds = l; v.exp_led = xl; v.exp_lvl = xv;
    vecs.push_back(v);
  endfunction

  task automatic wait_lvl(input int ch, input logic [3:0] target, input int budget, input string name);
    int n = 0;
    while (lvl(ch) != target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(lvl(ch)), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifm.leds_in = 8'h00;
    ifm.enable = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    int j;
    logic [3:0] prev;
    logic [3:0] seq [4];

    rst = 1'b1;
    rst_s = 1'b1;
    ifm.leds_in = 8'h00;
    ifm.enable = 1'b1;
    ifs.leds_in = 8'h00;
    ifs.enable = 1'b1;

    // Reset with all requests high, then release.
    for (int k = 0; k < 3; k++) add(1, 1, 8'hFF, 8'h00, 32'h0);
    add(0, 1, 8'hFF, 8'h00, 32'h0);
    add(0, 1, 8'hFF, 8'h00, 32'hFFFFFFFF);
    for (int k = 0; k < 6; k++) add(0, 1, 8'hFF, 8'hFF, 32'hFFFFFFFF);
    // Fresh reset, bit0 high for 5 edges, then low: hand-derived fade.
    add(1, 1, 8'h01, 8'h00, 32'h0);
    add(0, 1, 8'h01, 8'h00, 32'h0);   // e1
    add(0, 1, 8'h01, 8'h00, 32'hF);   // e2
    add(0, 1, 8'h01, 8'h01, 32'hF);   // e3
    add(0, 1, 8'h01, 8'h01, 32'hF);   // e4
    add(0, 1, 8'h01, 8'h01, 32'hF);   // e5
    add(0, 1, 8'h00, 8'h01, 32'hF);   // e6
    add(0, 1, 8'h00, 8'h01, 32'hF);   // e7
    add(0, 1, 8'h00, 8'h01, 32'hB);   // e8
    add(0, 1, 8'h00, 8'h01, 32'hB);   // e9
    add(0, 1, 8'h00, 8'h01, 32'hB);   // e10
    add(0, 1, 8'h00, 8'h01, 32'hB);   // e11
    add(0, 1, 8'h00, 8'h00, 32'h7);   // e12
    add(0, 1, 8'h00, 8'h00, 32'h7);   // e13
    add(0, 1, 8'h00, 8'h00, 32'h7);   // e14
    add(0, 1, 8'h00, 8'h00, 32'h7);   // e15
    add(0, 1, 8'h00, 8'h01, 32'h3);   // e16
    add(0, 1, 8'h00, 8'h01, 32'h3);   // e17
    add(0, 1, 8'h00, 8'h01, 32'h3);   // e18
    add(0, 1, 8'h00, 8'h00, 32'h3);   // e19
    add(0, 1, 8'h00, 8'h00, 32'h0);   // e20
    add(0, 1, 8'h00, 8'h00, 32'h0);   // e21
    add(0, 1, 8'h00, 8'h00, 32'h0);   // e22

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      ifm.enable = vecs[i].en;
      ifm.leds_in = vecs[i].leds;
      tick();
      check($sformatf("vec%0d led_out", i), 32'(ifm.led_out), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d level_dbg", i), ifm.level_dbg, vecs[i].exp_lvl);
    end

    // Shifter step 0x1F -> 0x3E.
    do_reset();
    ifm.leds_in = 8'h1F;
    repeat (3) tick();
    check("shift levels full", ifm.level_dbg, 32'h000FFFFF);
    ifm.leds_in = 8'h3E;
    tick();
    check("shift level5 edge1", 32'(lvl(5)), 32'h0);
    tick();
    check("shift level5 edge2", 32'(lvl(5)), 32'hF);
    seq[0] = 4'd11; seq[1] = 4'd7; seq[2] = 4'd3; seq[3] = 4'd0;
    j = 0;
    prev = lvl(0);
    for (int c = 0; c < 24; c++) begin
      tick();
      if (lvl(0) != prev) begin
        if (j < 4) check($sformatf("shift trail step%0d", j), 32'(lvl(0)), 32'(seq[j]));
        else check("shift trail extra step", 32'(lvl(0)), 32'(prev));
        j++;
        prev = lvl(0);
      end
    end
    check("shift trail steps", 32'(j), 32'd4);
    check("shift levels 1-5", ifm.level_dbg, 32'h00FFFFF0);

    // Retrigger, freeze, resume.
    do_reset();
    ifm.leds_in = 8'h01;
    repeat (3) tick();
    ifm.leds_in = 8'h00;
    wait_lvl(0, 4'd7, 20, "retrig reach 7");
    ifm.leds_in = 8'h01;
    tick();
    tick();
    check("retrig level0", 32'(lvl(0)), 32'hF);
    ifm.leds_in = 8'h00;
    wait_lvl(0, 4'd11, 12, "retrig decay to 11");
    ifm.enable = 1'b0;
    ifm.leds_in = 8'h80;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("freeze led_out c%0d", c), 32'(ifm.led_out), 32'h0);
      check($sformatf("freeze level_dbg c%0d", c), ifm.level_dbg, 32'h0000000B);
    end
    ifm.enable = 1'b1;
    ifm.leds_in = 8'h00;
    tick();
    check("resume level7 from sampled input", 32'(lvl(7)), 32'hF);
    wait_lvl(0, 4'd7, 4, "resume decay 11->7");

    // Reset mid-fade.
    do_reset();
    ifm.leds_in = 8'h01;
    repeat (3) tick();
    ifm.leds_in = 8'h00;
    wait_lvl(0, 4'd7, 20, "midreset reach 7");
    rst = 1'b1;
    tick();
    check("midreset level_dbg", ifm.level_dbg, 32'h0);
    check("midreset led_out", 32'(ifm.led_out), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c % 5 == 4) begin
        check($sformatf("postreset level c%0d", c), ifm.level_dbg, 32'h0);
        check($sformatf("postreset led c%0d", c), 32'(ifm.led_out), 32'h0);
      end
    end

    // Duty at level 11 with a slow decay prescaler.
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    ifs.leds_in = 8'h01;
    repeat (3) tick();
    check("duty full level", 32'(lvl_s(0)), 32'hF);
    ifs.leds_in = 8'h00;
    begin
      int n = 0;
      while (lvl_s(0) != 4'd11 && n < 80) begin
        tick();
        n++;
      end
    end
    check("duty reach 11", 32'(lvl_s(0)), 32'd11);
    tick();
    ones = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (ifs.led_out[0]) ones++;
    end
    check("duty ones of 15", 32'(ones), 32'd11);
    check("duty level held", 32'(lvl_s(0)), 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
